// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared hypervector constants and search state encoding
package hdc_pkg;

    // Segments per hypervector; the query and every class HV are streamed in this many chunks.
    localparam int SEQ_CYCLE_COUNT = 4;
    localparam int SEG_W           = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } search_state_t;

endpackage

// File: rtl/hv_assoc_search_if.sv
// rtl/hv_assoc_search_if.sv - query segment stream and class memory read bus
// Ports/signals:
//   q_valid, q_chunk : query segment offered by the upstream encoder
//   q_ready          : search block accepts the offered segment this cycle
//   cls_idx          : segment index presented to the class memory
//   cls_chunk        : segment cls_idx of every class, class c at [c*CHUNK_W +: CHUNK_W]
interface hv_assoc_search_if
    import hdc_pkg::*;
#(
    parameter int NUM_CLASSES = 4,
    parameter int CHUNK_W     = 64
);
    logic                           q_valid;
    logic [CHUNK_W-1:0]             q_chunk;
    logic                           q_ready;
    logic [SEG_W-1:0]               cls_idx;
    logic [NUM_CLASSES*CHUNK_W-1:0] cls_chunk;

    // slave: the search block; master: query source plus class memory
    modport slave  (input  q_valid, q_chunk, cls_chunk, output q_ready, cls_idx);
    modport master (output q_valid, q_chunk, cls_chunk, input  q_ready, cls_idx);
endinterface

// File: rtl/hv_popcount.sv
// rtl/hv_popcount.sv - combinational popcount built as a binary adder tree
// Ports:
//   i_bits  : input word
//   o_count : number of set bits in i_bits
module hv_popcount #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_bits,
    output logic [CNT_W-1:0] o_count
);
    localparam int LVLS  = $clog2(WIDTH);
    localparam int PAD_W = 1 << LVLS;

    // Pad to a power of two so every tree level halves cleanly.
    logic [PAD_W-1:0] w_pad;
    assign w_pad = PAD_W'(i_bits);

    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        localparam int N = PAD_W >> l;
        logic [N-1:0][CNT_W-1:0] w_sum;
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign w_sum[i] = CNT_W'(w_pad[i]);
            end
        end else begin : g_node
            for (genvar i = 0; i < N; i++) begin : g_add
                assign w_sum[i] = g_lvl[l-1].w_sum[2*i] + g_lvl[l-1].w_sum[2*i+1];
            end
        end
    end

    assign o_count = g_lvl[LVLS].w_sum[0];
endmodule

// File: rtl/hv_assoc_search.sv
// rtl/hv_assoc_search.sv - associative search: per-class Hamming accumulation and argmin
// Ports:
//   clk, nrst  : clock, asynchronous active-low reset
//   en         : global enable, low freezes all state
//   start      : begin a search (honoured in idle only), prune_mask latched here
//   prune_mask : bit k set keeps segment k in the distance
//   bus        : query stream in, class memory read out
//   busy, done : search in progress / one-cycle result strobe
//   class_out  : predicted class, min_dist its distance; held between searches
module hv_assoc_search
    import hdc_pkg::*;
#(
    parameter int NUM_CLASSES = 4,
    parameter int CHUNK_W     = 64,
    parameter int DIST_W      = $clog2(CHUNK_W * SEQ_CYCLE_COUNT + 1)
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           en,
    input  logic                           start,
    input  logic [SEQ_CYCLE_COUNT-1:0]     prune_mask,
    hv_assoc_search_if.slave               bus,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_CLASSES)-1:0] class_out,
    output logic [DIST_W-1:0]              min_dist
);
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int CNT_W = $clog2(CHUNK_W + 1);

    search_state_t              r_state, w_state_next;
    logic [SEQ_CYCLE_COUNT-1:0] r_mask;
    logic [SEG_W-1:0]           r_seg;
    logic [CLS_W-1:0]           r_scan, r_best_idx;
    logic [DIST_W-1:0]          r_best;
    logic [DIST_W-1:0]          r_acc [NUM_CLASSES];
    logic [CNT_W-1:0]           w_pop [NUM_CLASSES];

    logic w_q_ready, w_beat, w_last_seg, w_last_scan, w_take;
    logic [DIST_W-1:0] w_cand, w_best_nx;
    logic [CLS_W-1:0]  w_idx_nx;

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pop
        hv_popcount #(.WIDTH(CHUNK_W)) u_pop (
            .i_bits  (bus.q_chunk ^ bus.cls_chunk[c*CHUNK_W +: CHUNK_W]),
            .o_count (w_pop[c])
        );
    end

    assign w_beat      = bus.q_valid && w_q_ready;
    assign w_last_seg  = (r_seg == SEG_W'(SEQ_CYCLE_COUNT - 1));
    assign w_last_scan = (r_scan == CLS_W'(NUM_CLASSES - 1));

    // Argmin step: the first scanned class seeds the best; strict compare keeps the lowest index on ties.
    assign w_cand    = r_acc[r_scan];
    assign w_take    = (r_scan == '0) || (w_cand < r_best);
    assign w_best_nx = w_take ? w_cand : r_best;
    assign w_idx_nx  = w_take ? r_scan : r_best_idx;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else if (en) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)                 w_state_next = S_ACCUM;
            S_ACCUM: if (w_beat && w_last_seg)  w_state_next = S_SCAN;
            S_SCAN:  if (w_last_scan)           w_state_next = S_DONE;
            S_DONE:                             w_state_next = S_IDLE;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_q_ready   = (r_state == S_ACCUM) && en;
        done        = (r_state == S_DONE) && en;
        busy        = (r_state != S_IDLE);
        bus.cls_idx = (r_state == S_ACCUM) ? r_seg : '0;
    end
    assign bus.q_ready = w_q_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mask     <= '0;
            r_seg      <= '0;
            r_scan     <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            class_out  <= '0;
            min_dist   <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
        end else if (en) begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_mask <= prune_mask;
                    r_seg  <= '0;
                    for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
                end
                S_ACCUM: if (w_beat) begin
                    if (r_mask[r_seg]) begin
                        for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= r_acc[c] + DIST_W'(w_pop[c]);
                    end
                    r_seg  <= w_last_seg ? '0 : r_seg + 1'b1;
                    r_scan <= '0;
                end
                S_SCAN: begin
                    r_best     <= w_best_nx;
                    r_best_idx <= w_idx_nx;
                    r_scan     <= w_last_scan ? '0 : r_scan + 1'b1;
                    // Publish on the final compare so the result is stable while done is high.
                    if (w_last_scan) begin
                        class_out <= w_idx_nx;
                        min_dist  <= w_best_nx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hv_assoc_search.sv
// tb/tb_hv_assoc_search.sv - randomized self-checking bench for hv_assoc_search
module tb_hv_assoc_search;
    import hdc_pkg::*;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int NS = SEQ_CYCLE_COUNT;

    logic        clk = 1'b0;
    logic        nrst, en, start;
    logic [3:0]  prune_mask;
    logic        busy, done;
    logic [1:0]  class_out;
    logic [5:0]  min_dist;

    logic [CW-1:0] q_mem   [NS];
    logic [CW-1:0] cls_mem [NC][NS];

    int n_tests = 0;
    int n_fail  = 0;

    hv_assoc_search_if #(.NUM_CLASSES(NC), .CHUNK_W(CW)) bus ();

    hv_assoc_search #(.NUM_CLASSES(NC), .CHUNK_W(CW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .start      (start),
        .prune_mask (prune_mask),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .class_out  (class_out),
        .min_dist   (min_dist)
    );

    always #5 clk = ~clk;

    // Class memory with same-cycle read of the presented segment index.
    always_comb begin
        bus.cls_chunk = '0;
        for (int c = 0; c < NC; c++) bus.cls_chunk[c*CW +: CW] = cls_mem[c][bus.cls_idx];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: Hamming distance over kept segments, then first minimum.
    task automatic model(input logic [3:0] mask, output int ecls, output int edist);
        int d;
        edist = 1 << 30;
        ecls  = 0;
        for (int c = 0; c < NC; c++) begin
            d = 0;
            for (int s = 0; s < NS; s++)
                if (mask[s]) d += $countones(q_mem[s] ^ cls_mem[c][s]);
            if (d < edist) begin
                edist = d;
                ecls  = c;
            end
        end
    endtask

    task automatic set_q(input logic [31:0] v);
        for (int s = 0; s < NS; s++) q_mem[s] = v[s*CW +: CW];
    endtask

    task automatic set_cls(input int c, input logic [31:0] v);
        for (int s = 0; s < NS; s++) cls_mem[c][s] = v[s*CW +: CW];
    endtask

    function automatic logic [31:0] flip3();
        logic [31:0] f;
        f = '0;
        while ($countones(f) < 3) f[$urandom_range(31)] = 1'b1;
        return f;
    endfunction

    task automatic randomize_mem();
        set_q($urandom);
        for (int c = 0; c < NC; c++) set_cls(c, $urandom);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk($sformatf("%s_busy", tag), busy, 0);
        chk($sformatf("%s_done", tag), done, 0);
        chk($sformatf("%s_qrdy", tag), bus.q_ready, 0);
        chk($sformatf("%s_idx", tag), bus.cls_idx, 0);
        chk($sformatf("%s_cls", tag), class_out, 0);
        chk($sformatf("%s_dist", tag), min_dist, 0);
    endtask

    // One search. Cycle 0 is the start cycle; without gaps or stalls beats land on cycles 1..4 and done on 9.
    task automatic run_search(input string tag, input logic [3:0] mask, input int gap_pct,
                              input int stall_at, input int stall_len, input bit start_in_scan);
        int ecls, edist, beat, gaps, stalls, done_cyc;
        bit scan_started;
        model(mask, ecls, edist);
        @(negedge clk);
        en = 1'b1; start = 1'b1; prune_mask = mask; bus.q_valid = 1'b0;
        @(posedge clk);
        beat = 0; gaps = 0; stalls = 0; done_cyc = -1; scan_started = 1'b0;
        for (int cyc = 1; cyc <= 80 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start      = 1'b0;
            prune_mask = 4'($urandom);
            en         = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (start_in_scan && beat == NS && !scan_started) begin
                start        = 1'b1;
                scan_started = 1'b1;
            end
            if (beat < NS) begin
                bus.q_valid = ($urandom_range(99) >= gap_pct);
                bus.q_chunk = q_mem[beat];
            end else begin
                bus.q_valid = 1'($urandom_range(1));
                bus.q_chunk = 8'($urandom);
            end
            #1;
            if (!en) begin
                stalls++;
                chk($sformatf("%s_stall_qrdy", tag), bus.q_ready, 0);
                chk($sformatf("%s_stall_done", tag), done, 0);
            end else if (beat < NS) begin
                if (bus.q_valid) begin
                    chk($sformatf("%s_qrdy%0d", tag, beat), bus.q_ready, 1);
                    chk($sformatf("%s_idx%0d", tag, beat), bus.cls_idx, beat);
                    beat++;
                end else begin
                    gaps++;
                end
            end else if (done) begin
                done_cyc = cyc;
            end
        end
        if (done_cyc < 0) begin
            chk($sformatf("%s_timeout", tag), 0, 1);
        end else begin
            chk($sformatf("%s_cls", tag), class_out, ecls);
            chk($sformatf("%s_dist", tag), min_dist, edist);
            chk($sformatf("%s_lat", tag), done_cyc, 9 + gaps + stalls);
        end
        @(negedge clk);
        start = 1'b0; en = 1'b1; bus.q_valid = 1'b0;
        #1;
        chk($sformatf("%s_pulse", tag), done, 0);
        chk($sformatf("%s_idle", tag), busy, 0);
    endtask

    initial begin
        nrst = 1'b0; en = 1'b0; start = 1'b0; prune_mask = '0;
        bus.q_valid = 1'b0; bus.q_chunk = '0;
        randomize_mem();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        nrst = 1'b1;

        // Exact match with class 2.
        randomize_mem();
        set_cls(2, {q_mem[3], q_mem[2], q_mem[1], q_mem[0]});
        run_search("exact2", 4'hF, 0, 100, 0, 1'b0);

        // Reset mid-accumulation: no done, everything back to zero.
        randomize_mem();
        @(negedge clk);
        start = 1'b1; prune_mask = 4'hF; en = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            start = 1'b0; bus.q_valid = 1'b1; bus.q_chunk = q_mem[b];
            @(posedge clk);
        end
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.q_valid = 1'b1;
            #1;
            chk($sformatf("midrst_nodone%0d", i), done | busy, 0);
        end
        bus.q_valid = 1'b0;

        // Tie between class 0 and 1 at three bits.
        randomize_mem();
        begin
            logic [31:0] qv;
            qv = $urandom;
            set_q(qv);
            set_cls(0, qv ^ flip3());
            set_cls(1, qv ^ flip3());
            set_cls(2, ~qv);
            set_cls(3, ~qv ^ 32'h1);
            run_search("tie", 4'hF, 0, 100, 0, 1'b0);
            chk("tie_cls_abs", class_out, 0);
            chk("tie_dist_abs", min_dist, 3);

            // Only segment 1 differs for class 0, and that segment is pruned.
            set_cls(0, qv ^ 32'h0000_FF00);
            for (int c = 1; c < NC; c++) set_cls(c, $urandom);
            run_search("prune1", 4'b1101, 0, 100, 0, 1'b0);
        end

        // Enable dropped for three cycles mid-accumulation with input gaps.
        randomize_mem();
        run_search("stall", 4'hF, 30, 2, 3, 1'b0);

        // Start asserted while scanning is ignored.
        randomize_mem();
        run_search("scanstart", 4'hF, 0, 100, 0, 1'b1);

        // Every segment pruned.
        randomize_mem();
        run_search("mask0", 4'h0, 0, 100, 0, 1'b0);
        chk("mask0_cls_abs", class_out, 0);
        chk("mask0_dist_abs", min_dist, 0);

        // Randomized searches.
        for (int t = 0; t < 24; t++) begin
            randomize_mem();
            if ($urandom_range(3) == 0) begin
                int k;
                k = $urandom_range(NC - 1);
                set_cls(k, {q_mem[3], q_mem[2], q_mem[1], q_mem[0]} ^ (32'h1 << $urandom_range(31)));
            end
            run_search($sformatf("rnd%0d", t), 4'($urandom), $urandom_range(40),
                       $urandom_range(1, 12), $urandom_range(0, 3), 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
